bus_xfer_ctrl: RTL and testbench

Issue side of the datapath bus. It accepts register-transfer requests (source code, destination code) from the control unit and buffers them in a small FIFO. It then issues one transfer per cycle by driving the 5-bit bus-mux select and a one-hot destination load enable in the same cycle. It owns every bus transfer: source encoding toward the 32-to-1 bus mux, and destination decoding toward the register load enables.

---
 rtl/bus_codes_pkg.sv | 75 +++++++
 rtl/xfer_fifo.sv | 55 +++++
 rtl/bus_xfer_ctrl.sv | 79 +++++++
 tb/tb_bus_xfer_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_codes_pkg.sv
// Shared bus encodings: source/destination codes, transfer entry layout and
// the issue FSM state type, used by the bus mux, control unit and issue logic.
package bus_codes_pkg;

  localparam int CODE_W  = 5;
  localparam int NUM_SRC = 24;
  localparam int NUM_DST = 24;

  localparam logic [CODE_W-1:0] SRC_R0      = 5'd0;
  localparam logic [CODE_W-1:0] SRC_R1      = 5'd1;
  localparam logic [CODE_W-1:0] SRC_R2      = 5'd2;
  localparam logic [CODE_W-1:0] SRC_R3      = 5'd3;
  localparam logic [CODE_W-1:0] SRC_R4      = 5'd4;
  localparam logic [CODE_W-1:0] SRC_R5      = 5'd5;
  localparam logic [CODE_W-1:0] SRC_R6      = 5'd6;
  localparam logic [CODE_W-1:0] SRC_R7      = 5'd7;
  localparam logic [CODE_W-1:0] SRC_R8      = 5'd8;
  localparam logic [CODE_W-1:0] SRC_R9      = 5'd9;
  localparam logic [CODE_W-1:0] SRC_R10     = 5'd10;
  localparam logic [CODE_W-1:0] SRC_R11     = 5'd11;
  localparam logic [CODE_W-1:0] SRC_R12     = 5'd12;
  localparam logic [CODE_W-1:0] SRC_R13     = 5'd13;
  localparam logic [CODE_W-1:0] SRC_R14     = 5'd14;
  localparam logic [CODE_W-1:0] SRC_R15     = 5'd15;
  localparam logic [CODE_W-1:0] SRC_HI      = 5'd16;
  localparam logic [CODE_W-1:0] SRC_LO      = 5'd17;
  localparam logic [CODE_W-1:0] SRC_ZHIGH   = 5'd18;
  localparam logic [CODE_W-1:0] SRC_ZLOW    = 5'd19;
  localparam logic [CODE_W-1:0] SRC_PC      = 5'd20;
  localparam logic [CODE_W-1:0] SRC_MDR     = 5'd21;
  localparam logic [CODE_W-1:0] SRC_INPORT  = 5'd22;
  localparam logic [CODE_W-1:0] SRC_CSIGN   = 5'd23;

  localparam logic [CODE_W-1:0] DST_R0      = 5'd0;
  localparam logic [CODE_W-1:0] DST_R1      = 5'd1;
  localparam logic [CODE_W-1:0] DST_R2      = 5'd2;
  localparam logic [CODE_W-1:0] DST_R3      = 5'd3;
  localparam logic [CODE_W-1:0] DST_R4      = 5'd4;
  localparam logic [CODE_W-1:0] DST_R5      = 5'd5;
  localparam logic [CODE_W-1:0] DST_R6      = 5'd6;
  localparam logic [CODE_W-1:0] DST_R7      = 5'd7;
  localparam logic [CODE_W-1:0] DST_R8      = 5'd8;
  localparam logic [CODE_W-1:0] DST_R9      = 5'd9;
  localparam logic [CODE_W-1:0] DST_R10     = 5'd10;
  localparam logic [CODE_W-1:0] DST_R11     = 5'd11;
  localparam logic [CODE_W-1:0] DST_R12     = 5'd12;
  localparam logic [CODE_W-1:0] DST_R13     = 5'd13;
  localparam logic [CODE_W-1:0] DST_R14     = 5'd14;
  localparam logic [CODE_W-1:0] DST_R15     = 5'd15;
  localparam logic [CODE_W-1:0] DST_HI      = 5'd16;
  localparam logic [CODE_W-1:0] DST_LO      = 5'd17;
  localparam logic [CODE_W-1:0] DST_PC      = 5'd18;
  localparam logic [CODE_W-1:0] DST_MDR     = 5'd19;
  localparam logic [CODE_W-1:0] DST_MAR     = 5'd20;
  localparam logic [CODE_W-1:0] DST_IR      = 5'd21;
  localparam logic [CODE_W-1:0] DST_Y       = 5'd22;
  localparam logic [CODE_W-1:0] DST_OUTPORT = 5'd23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } state_t;

  typedef struct packed {
    logic [CODE_W-1:0] src;
    logic [CODE_W-1:0] dst;
  } xfer_t;

  function automatic logic isLegal(input logic [CODE_W-1:0] src,
                                   input logic [CODE_W-1:0] dst);
    return (src < CODE_W'(NUM_SRC)) && (dst < CODE_W'(NUM_DST));
  endfunction

endpackage

// File: rtl/xfer_fifo.sv
// Request queue: DEPTH x 10-bit synchronous FIFO with a separate occupancy
// counter; pointers wrap naturally because DEPTH is a power of two.
module xfer_fifo
  import bus_codes_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  xfer_t                      wrData,
  output xfer_t                      rdData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  xfer_t            mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == OCC_W'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign rdData = mem[rdPtr];

  // NOTE: storage has no reset; an entry is only visible once count covers it.
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Bus transfer issue controller: queues (src, dst) requests and issues one
// per cycle as a registered mux select plus a one-hot destination load enable.
module bus_xfer_ctrl #(
  parameter int DEPTH   = 4,
  parameter int NUM_DST = 24,
  parameter int CNT_W   = 16
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [4:0]                 req_src,
  input  logic [4:0]                 req_dst,
  input  logic                       hold,
  output logic [4:0]                 select_signal,
  output logic [NUM_DST-1:0]         load_en,
  output logic                       xfer_active,
  output logic                       err_pulse,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic [CNT_W-1:0]           xfer_count
);

  import bus_codes_pkg::*;

  state_t state;
  xfer_t  head;
  logic   full;
  logic   empty;
  logic   accept;
  logic   legal;
  logic   push;
  logic   pop;

  assign req_ready = !full;
  assign accept    = req_valid && req_ready;
  assign legal     = isLegal(req_src, req_dst);
  assign push      = accept && legal;
  assign pop       = !empty && !hold;

  xfer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock  (clock),
    .clear  (clear),
    .push   (push),
    .pop    (pop),
    .wrData ('{src: req_src, dst: req_dst}),
    .rdData (head),
    .full   (full),
    .empty  (empty),
    .count  (fifo_count)
  );

  assign xfer_active = (state == ISSUE);

  // Select and enable are written in the same branch so they never disagree.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state         <= IDLE;
      select_signal <= '0;
      load_en       <= '0;
      err_pulse     <= 1'b0;
      xfer_count    <= '0;
    end else begin
      err_pulse <= accept && !legal;
      if (empty) begin
        state   <= IDLE;
        load_en <= '0;
      end else if (hold) begin
        state   <= STALL;
        load_en <= '0;
      end else begin
        state         <= ISSUE;
        select_signal <= head.src;
        load_en       <= {{(NUM_DST-1){1'b0}}, 1'b1} << head.dst;
        xfer_count    <= xfer_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl: each task drives one scenario and compares
// outputs against hand-computed values one time unit after the rising edge.
module tb_bus_xfer_ctrl;

  localparam int DEPTH   = 4;
  localparam int NUM_DST = 24;
  localparam int CNT_W   = 4;

  logic                       clock;
  logic                       clear;
  logic                       req_valid;
  logic                       req_ready;
  logic [4:0]                 req_src;
  logic [4:0]                 req_dst;
  logic                       hold;
  logic [4:0]                 select_signal;
  logic [NUM_DST-1:0]         load_en;
  logic                       xfer_active;
  logic                       err_pulse;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  logic [CNT_W-1:0]           xfer_count;

  int vectors    = 0;
  int miscompares = 0;

  bus_xfer_ctrl #(.DEPTH(DEPTH), .NUM_DST(NUM_DST), .CNT_W(CNT_W)) dut (
    .clock         (clock),
    .clear         (clear),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_src       (req_src),
    .req_dst       (req_dst),
    .hold          (hold),
    .select_signal (select_signal),
    .load_en       (load_en),
    .xfer_active   (xfer_active),
    .err_pulse     (err_pulse),
    .fifo_count    (fifo_count),
    .xfer_count    (xfer_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setReq(input logic v, input logic [4:0] s, input logic [4:0] d);
    req_valid = v;
    req_src   = s;
    req_dst   = d;
  endtask

  task automatic applyReset();
    clear = 1'b0;
    setReq(1'b0, 5'd0, 5'd0);
    hold = 1'b0;
    repeat (2) @(posedge clock);
    #1 clear = 1'b1;
    tick();
  endtask

  task automatic checkIssue(input string tag, input logic [4:0] s, input logic [4:0] d);
    logic [NUM_DST-1:0] expEn;
    expEn = '0;
    expEn[d] = 1'b1;
    vectors++;
    if (select_signal !== s || load_en !== expEn || xfer_active !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: sel=%0d en=%h act=%b, required sel=%0d en=%h act=1",
               tag, select_signal, load_en, xfer_active, s, expEn);
    end
  endtask

  task automatic checkQuiet(input string tag, input logic [4:0] s);
    vectors++;
    if (load_en !== '0 || xfer_active !== 1'b0 || select_signal !== s) begin
      miscompares++;
      $display("FAIL %s: sel=%0d en=%h act=%b, required sel=%0d en=0 act=0",
               tag, select_signal, load_en, xfer_active, s);
    end
  endtask

  task automatic checkCounts(input string tag, input int fc, input int xc);
    vectors++;
    if (fifo_count !== fc[$bits(fifo_count)-1:0] || xfer_count !== xc[CNT_W-1:0]) begin
      miscompares++;
      $display("FAIL %s: fifo_count=%0d xfer_count=%0d, required %0d %0d",
               tag, fifo_count, xfer_count, fc, xc);
    end
  endtask

  task automatic test_reset();
    clear = 1'b0;
    setReq(1'b0, 5'd0, 5'd0);
    hold = 1'b0;
    #12;
    checkQuiet("reset_in", 5'd0);
    checkCounts("reset_in_cnt", 0, 0);
    vectors++;
    if (err_pulse !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_flags: err=%b ready=%b, required 0 1", err_pulse, req_ready);
    end
    @(posedge clock);
    #1 clear = 1'b1;
    tick();
    checkQuiet("reset_out", 5'd0);
  endtask

  task automatic test_single();
    setReq(1'b1, 5'd20, 5'd20);
    tick();
    setReq(1'b0, 5'd0, 5'd0);
    checkQuiet("single_accept", 5'd0);
    checkCounts("single_accept_cnt", 1, 0);
    tick();
    checkIssue("single_issue", 5'd20, 5'd20);
    vectors++;
    if (load_en !== 24'h100000) begin
      miscompares++;
      $display("FAIL single_en_value: en=%h, required 100000", load_en);
    end
    checkCounts("single_issue_cnt", 0, 1);
    tick();
    checkQuiet("single_after", 5'd20);
    checkCounts("single_after_cnt", 0, 1);
  endtask

  task automatic test_back_to_back();
    int peak = 0;
    setReq(1'b1, 5'd1, 5'd2);
    tick();
    if (fifo_count > peak) peak = fifo_count;
    checkQuiet("b2b_e1", 5'd20);
    setReq(1'b1, 5'd2, 5'd3);
    tick();
    if (fifo_count > peak) peak = fifo_count;
    checkIssue("b2b_i1", 5'd1, 5'd2);
    setReq(1'b1, 5'd16, 5'd4);
    tick();
    if (fifo_count > peak) peak = fifo_count;
    checkIssue("b2b_i2", 5'd2, 5'd3);
    setReq(1'b0, 5'd0, 5'd0);
    tick();
    checkIssue("b2b_i3", 5'd16, 5'd4);
    vectors++;
    if (load_en !== 24'h000010 || peak !== 1) begin
      miscompares++;
      $display("FAIL b2b_peak: en=%h peak=%0d, required 000010 1", load_en, peak);
    end
    checkCounts("b2b_cnt", 0, 4);
    tick();
    checkQuiet("b2b_idle", 5'd16);
  endtask

  task automatic test_full_hold();
    logic [4:0] srcs [5] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd31};
    logic [4:0] dsts [5] = '{5'd5, 5'd6, 5'd7, 5'd8, 5'd9};
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      setReq(1'b1, srcs[i], dsts[i]);
      vectors++;
      if (req_ready !== (i < 4)) begin
        miscompares++;
        $display("FAIL full_ready[%0d]: ready=%b, required %b", i, req_ready, (i < 4));
      end
      tick();
    end
    setReq(1'b0, 5'd0, 5'd0);
    vectors++;
    if (err_pulse !== 1'b0 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_no_legality: err=%b ready=%b, required 0 0", err_pulse, req_ready);
    end
    checkQuiet("full_stall", 5'd16);
    checkCounts("full_cnt", 4, 4);
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkIssue($sformatf("full_drain[%0d]", i), srcs[i], dsts[i]);
    end
    checkCounts("full_drain_cnt", 0, 8);
    tick();
    checkQuiet("full_idle", 5'd6);
  endtask

  task automatic test_illegal();
    setReq(1'b1, 5'd25, 5'd3);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_ready: ready=%b, required 1", req_ready);
    end
    tick();
    setReq(1'b0, 5'd0, 5'd0);
    vectors++;
    if (err_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_pulse: err=%b, required 1", err_pulse);
    end
    checkCounts("illegal_cnt", 0, 8);
    tick();
    vectors++;
    if (err_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_pulse_end: err=%b, required 0", err_pulse);
    end
    checkQuiet("illegal_no_load", 5'd6);
    setReq(1'b1, 5'd23, 5'd24);
    tick();
    setReq(1'b0, 5'd0, 5'd0);
    vectors++;
    if (err_pulse !== 1'b1 || fifo_count !== 0) begin
      miscompares++;
      $display("FAIL illegal_dst: err=%b fifo=%0d, required 1 0", err_pulse, fifo_count);
    end
    tick();
    checkQuiet("illegal_dst_no_load", 5'd6);
  endtask

  task automatic test_reset_mid();
    hold = 1'b1;
    setReq(1'b1, 5'd8, 5'd10);  tick();
    setReq(1'b1, 5'd9, 5'd11);  tick();
    setReq(1'b1, 5'd10, 5'd12); tick();
    setReq(1'b0, 5'd0, 5'd0);
    hold = 1'b0;
    tick();
    checkIssue("mid_issue", 5'd8, 5'd10);
    #2 clear = 1'b0;
    #1;
    checkQuiet("mid_async", 5'd0);
    checkCounts("mid_async_cnt", 0, 0);
    #1 clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkQuiet($sformatf("mid_no_stale[%0d]", i), 5'd0);
    end
    checkCounts("mid_after_cnt", 0, 0);
  endtask

  task automatic test_wrap();
    applyReset();
    for (int i = 0; i < 16; i++) begin
      setReq(1'b1, 5'(i), 5'(i));
      tick();
    end
    setReq(1'b0, 5'd0, 5'd0);
    checkIssue("wrap_pre", 5'd14, 5'd14);
    checkCounts("wrap_pre_cnt", 1, 15);
    tick();
    checkIssue("wrap_last", 5'd15, 5'd15);
    checkCounts("wrap_cnt", 0, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_hold();
    test_illegal();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
